// File: rtl/u_enc.sv
// u_enc: two-stage pipelined unary count to thermometer code encoder.
// Ports: clk, arst_n (async low reset); request i_in_vld/i_in_cnt
// (and i_in_inv when U_ENC_COMPLIMENT_EN is defined)/o_in_rdy;
// result o_out_vld/o_out_x/o_out_err/i_out_rdy; error counter
// o_err_cnt with synchronous clear i_err_clr.
module u_enc #(
  parameter int W = 16,
  localparam int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_in_vld,
  input  logic [CW-1:0] i_in_cnt,
`ifdef U_ENC_COMPLIMENT_EN
  input  logic          i_in_inv,
`endif
  output logic          o_in_rdy,
  output logic          o_out_vld,
  output logic [W-1:0]  o_out_x,
  output logic          o_out_err,
  input  logic          i_out_rdy,
  output logic [7:0]    o_err_cnt,
  input  logic          i_err_clr
);

  logic          s1_vld_q, s1_vld_d;
  logic [CW-1:0] s1_cnt_q, s1_cnt_d;
  logic          s1_err_q, s1_err_d;
  logic          s1_inv;
  logic          s2_vld_q, s2_vld_d;
  logic [W-1:0]  s2_x_q, s2_x_d;
  logic          s2_err_q, s2_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          s1_en, s2_en;
  logic [W-1:0]  therm;

  assign s2_en    = ~s2_vld_q | i_out_rdy;
  assign s1_en    = ~s1_vld_q | s2_en;
  assign o_in_rdy = s1_en;

`ifdef U_ENC_COMPLIMENT_EN
  logic s1_inv_q, s1_inv_d;

  always_comb begin
    s1_inv_d = s1_inv_q;
    if (s1_en && i_in_vld) s1_inv_d = i_in_inv;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) s1_inv_q <= 1'b0;
    else         s1_inv_q <= s1_inv_d;
  end

  assign s1_inv = s1_inv_q;
`else
  assign s1_inv = 1'b0;
`endif

  // S1: capture count and range check; data only moves on a real accept
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_cnt_d = s1_cnt_q;
    s1_err_d = s1_err_q;
    if (s1_en) begin
      s1_vld_d = i_in_vld;
      if (i_in_vld) begin
        s1_cnt_d = i_in_cnt;
        s1_err_d = int'(i_in_cnt) >= W;
      end
    end
  end

  always_comb begin
    therm = '0;
    for (int k = 0; k < W; k++) begin
      therm[k] = k < int'(s1_cnt_q);
    end
  end

  // S2: decode; out-of-range forces all-zero regardless of inversion
  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_x_d   = s2_x_q;
    s2_err_d = s2_err_q;
    if (s2_en) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_err_d = s1_err_q;
        if (s1_err_q)    s2_x_d = '0;
        else if (s1_inv) s2_x_d = ~therm;
        else             s2_x_d = therm;
      end
    end
  end

  // clear beats a simultaneous increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_err_clr) begin
      err_cnt_d = '0;
    end else if (s2_vld_q && i_out_rdy && s2_err_q
                 && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_vld_q  <= 1'b0;
      s1_cnt_q  <= '0;
      s1_err_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_x_q    <= '0;
      s2_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_cnt_q  <= s1_cnt_d;
      s1_err_q  <= s1_err_d;
      s2_vld_q  <= s2_vld_d;
      s2_x_q    <= s2_x_d;
      s2_err_q  <= s2_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_out_vld = s2_vld_q;
  assign o_out_x   = s2_x_q;
  assign o_out_err = s2_err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: doc/u_enc.md
U_ENC -- requirements
Module: u_enc

Interface
REQ-001 SHALL have parameter W, default 16, the code width in bits; legal range W >= 3.
REQ-002 SHALL have derived localparam CW = $clog2(W) + 1, the count width in bits; it is not overridable.
REQ-003 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port arst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_in_vld  input  1  request valid.
REQ-006 SHALL have port i_in_cnt  input  CW  unsigned unary count to encode.
REQ-007 SHALL have port i_in_inv  input  1  request complemented code; present only with U_ENC_COMPLIMENT_EN.
REQ-008 SHALL have port o_in_rdy  output  1  request accepted when i_in_vld & o_in_rdy.
REQ-009 SHALL have port o_out_vld  output  1  result valid.
REQ-010 SHALL have port o_out_x  output  W  thermometer-coded result.
REQ-011 SHALL have port o_out_err  output  1  the count was out of range.
REQ-012 SHALL have port i_out_rdy  input  1  result consumed when o_out_vld & i_out_rdy.
REQ-013 SHALL have port o_err_cnt  output  8  saturating count of errored results consumed.
REQ-014 SHALL have port i_err_clr  input  1  synchronous clear of o_err_cnt.

Function
REQ-015 SHALL encode a count n in 0..W-1 as o_out_x[k] = 1 for k < n, and 0 otherwise; n=0 gives all-zero.
REQ-016 SHALL treat n >= W as out of range: o_out_x = all-zero and o_out_err = 1; o_out_err SHALL be 0 for every in-range n.
REQ-017 SHALL use a two-stage pipeline: S1 registers the count, inverse flag and range check; S2 registers the decoded code and error flag.
REQ-018 SHALL present a result on o_out_* exactly 2 cycles after acceptance when not stalled.
REQ-019 SHALL advance S2 when s2_en = ~s2_vld | i_out_rdy.
REQ-020 SHALL advance S1 when s1_en = ~s1_vld | s2_en.
REQ-021 SHALL drive o_in_rdy = s1_en, combinationally; there are no bubbles, so throughput is 1 result per cycle.
REQ-022 SHALL hold o_out_vld, o_out_x and o_out_err stable while o_out_vld & ~i_out_rdy.
REQ-023 SHALL preserve results in acceptance order, with no loss or duplication under any i_out_rdy pattern.
REQ-024 SHALL increment o_err_cnt by 1 on each cycle where o_out_vld & i_out_rdy & o_out_err.
REQ-025 SHALL saturate o_err_cnt at 255 with no wrap-around.
REQ-026 SHALL clear o_err_cnt to 0 when i_err_clr = 1; clear wins over a simultaneous increment, and that increment is lost.
REQ-027 SHALL ignore i_in_cnt and i_in_inv when i_in_vld = 0, with no state change in S1.
REQ-028 SHALL NOT make the range check sensitive to the inverse flag.

Reset
REQ-029 SHALL, on arst_n = 0, asynchronously clear s1_vld, s2_vld and o_err_cnt.
REQ-030 SHALL hold o_out_vld = 0, o_out_x = 0, o_out_err = 0 and o_err_cnt = 0 throughout reset; o_in_rdy = 1 out of reset.
REQ-031 SHALL discard any in-flight results on reset assertion mid-operation; none are emitted after deassertion.

Configuration
REQ-032 SHALL compile in complement support when macro U_ENC_COMPLIMENT_EN is defined.
REQ-033 SHALL, with U_ENC_COMPLIMENT_EN defined and inv = 1, output the bitwise inverse of REQ-015 for in-range n (n=0 gives all-one).
REQ-034 SHALL output all-zero with err = 1 for out-of-range n regardless of inv.
REQ-035 SHALL, without U_ENC_COMPLIMENT_EN, omit port i_in_inv and the inv pipeline bit, and behave as inv = 0.

Verification
REQ-036 SHALL cover: W=16, i_out_rdy=1, accept n=4 at cycle t -> o_out_vld at t+2 with o_out_x=16'h000F and err=0.
REQ-037 SHALL cover: W=16, back-to-back n=0,1,15 -> consecutive results 16'h0000, 16'h0001, 16'h7FFF with no bubbles.
REQ-038 SHALL cover: W=16, n=16 and n=31 -> o_out_x=0 and err=1 each, and o_err_cnt goes 0→1→2.
REQ-039 SHALL cover: i_out_rdy=0 for 5 cycles while feeding n=2,3,4 -> o_in_rdy drops after 2 accepts, outputs hold 16'h0003, then the results drain in order once i_out_rdy=1.
REQ-040 SHALL cover: with U_ENC_COMPLIMENT_EN, inv=1, n=1 -> 16'hFFFE; inv=1, n=0 -> 16'hFFFF.
REQ-041 SHALL cover: 300 errored results -> o_err_cnt=255; i_err_clr coincident with an errored consume -> 0; arst_n pulsed with 2 results in flight -> no o_out_vld after release.
